// File: rtl/mapper_mmc1_ctrl.sv
// MMC1 mapper control: serial 5-bit register loading through a shift register,
// plus combinational PRG/CHR bank, mirroring and PRG-RAM enable decode.
module mapper_mmc1_ctrl (
  input  logic        clkCPU,
  input  logic        reset,
  input  logic        enable,
  input  logic [15:0] sys_addr,
  input  logic [7:0]  sys_data,
  input  logic        sys_rw,
  input  logic [13:0] ppu_addr,
  output logic [3:0]  prg_bank,
  output logic [4:0]  chr_bank,
  output logic [1:0]  mirroring,
  output logic        prg_ram_en
);

  logic [4:0] shift, shift_n;
  logic [2:0] count, count_n;
  logic [4:0] control, control_n;
  logic [4:0] chr0, chr0_n;
  logic [4:0] chr1, chr1_n;
  logic [4:0] prg, prg_n;
  logic       prev_wr;
  logic       write_ev;
  logic       accept;
  logic [4:0] load_val;
  logic       unused_bits;

  assign write_ev = enable & ~sys_rw & sys_addr[15];
  // The second edge of a read-modify-write double store must not shift.
  assign accept   = write_ev & ~prev_wr;

  assign unused_bits = ^{sys_data[6:1], sys_addr[12:0], ppu_addr[13], ppu_addr[11:0]};

  // State register
  always_ff @(posedge clkCPU or posedge reset) begin
    if (reset) begin
      shift   <= 5'h00;
      count   <= 3'd0;
      prev_wr <= 1'b0;
      control <= 5'h0C;
      chr0    <= 5'h00;
      chr1    <= 5'h00;
      prg     <= 5'h00;
    end else begin
      shift   <= shift_n;
      count   <= count_n;
      prev_wr <= write_ev;
      control <= control_n;
      chr0    <= chr0_n;
      chr1    <= chr1_n;
      prg     <= prg_n;
    end
  end

  // Next-state logic
  always_comb begin
    shift_n   = shift;
    count_n   = count;
    control_n = control;
    chr0_n    = chr0;
    chr1_n    = chr1;
    prg_n     = prg;
    load_val  = {sys_data[0], shift[4:1]};
    if (accept) begin
      if (sys_data[7]) begin
        shift_n   = 5'h00;
        count_n   = 3'd0;
        control_n = control | 5'h0C;
      end else if (count != 3'd4) begin
        shift_n = load_val;
        count_n = count + 3'd1;
      end else begin
        shift_n = 5'h00;
        count_n = 3'd0;
        case (sys_addr[14:13])
          2'd0:    control_n = load_val;
          2'd1:    chr0_n    = load_val;
          2'd2:    chr1_n    = load_val;
          default: prg_n     = load_val;
        endcase
      end
    end
  end

  // Output decode
  always_comb begin
    case (control[3:2])
      2'd2:    prg_bank = sys_addr[14] ? prg[3:0] : 4'h0;
      2'd3:    prg_bank = sys_addr[14] ? 4'hF : prg[3:0];
      default: prg_bank = {prg[3:1], sys_addr[14]};
    endcase
    if (control[4])
      chr_bank = ppu_addr[12] ? chr1 : chr0;
    else
      chr_bank = {chr0[4:1], ppu_addr[12]};
    mirroring  = control[1:0];
    prg_ram_en = enable & ~prg[4];
  end

endmodule

// File: tb/tb_mapper_mmc1_ctrl.sv
// Directed self-checking bench for mapper_mmc1_ctrl; expected values hand-derived.
module tb_mapper_mmc1_ctrl;

  logic        clkCPU = 1'b0;
  logic        reset;
  logic        enable;
  logic [15:0] sys_addr;
  logic [7:0]  sys_data;
  logic        sys_rw;
  logic [13:0] ppu_addr;
  logic [3:0]  prg_bank;
  logic [4:0]  chr_bank;
  logic [1:0]  mirroring;
  logic        prg_ram_en;

  int checks   = 0;
  int failures = 0;

  mapper_mmc1_ctrl dut (
    .clkCPU     (clkCPU),
    .reset      (reset),
    .enable     (enable),
    .sys_addr   (sys_addr),
    .sys_data   (sys_data),
    .sys_rw     (sys_rw),
    .ppu_addr   (ppu_addr),
    .prg_bank   (prg_bank),
    .chr_bank   (chr_bank),
    .mirroring  (mirroring),
    .prg_ram_en (prg_ram_en)
  );

  always #5 clkCPU = ~clkCPU;

  task automatic check(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // One write sampled at a single rising edge, followed by an idle edge.
  task automatic do_write(input logic [15:0] addr, input logic [7:0] data);
    @(negedge clkCPU);
    sys_rw   = 1'b0;
    sys_addr = addr;
    sys_data = data;
    @(negedge clkCPU);
    sys_rw   = 1'b1;
    sys_addr = 16'h0000;
    @(negedge clkCPU);
  endtask

  task automatic write5(input logic [15:0] addr, input logic [4:0] val);
    for (int i = 0; i < 5; i++) do_write(addr, {7'b0, val[i]});
  endtask

  task automatic probe_prg(input string tag, input logic [3:0] at8000, input logic [3:0] atc000);
    sys_addr = 16'h8000; #1;
    check({tag, "_prg8000"}, {4'h0, prg_bank}, {4'h0, at8000});
    sys_addr = 16'hC000; #1;
    check({tag, "_prgC000"}, {4'h0, prg_bank}, {4'h0, atc000});
    sys_addr = 16'h0000;
  endtask

  task automatic probe_chr(input string tag, input logic [4:0] lo, input logic [4:0] hi);
    ppu_addr = 14'h0000; #1;
    check({tag, "_chr0000"}, {3'h0, chr_bank}, {3'h0, lo});
    ppu_addr = 14'h1000; #1;
    check({tag, "_chr1000"}, {3'h0, chr_bank}, {3'h0, hi});
    ppu_addr = 14'h0000;
  endtask

  initial begin
    reset    = 1'b1;
    enable   = 1'b1;
    sys_addr = 16'h0000;
    sys_data = 8'h00;
    sys_rw   = 1'b1;
    ppu_addr = 14'h0000;
    #12;
    // Reset values, checked while reset is still asserted
    probe_prg("rst", 4'h0, 4'hF);
    probe_chr("rst", 5'd0, 5'd1);
    check("rst_mirroring", {6'h0, mirroring}, 8'd0);
    check("rst_ram_en_on", {7'h0, prg_ram_en}, 8'd1);
    enable = 1'b0; #1;
    check("rst_ram_en_off", {7'h0, prg_ram_en}, 8'd0);
    enable = 1'b1;
    @(negedge clkCPU);
    reset = 1'b0;

    // prg = 5'h05 via $E000, PRG mode 3
    write5(16'hE000, 5'h05);
    probe_prg("prg05", 4'h5, 4'hF);

    // control = 5'h10, chr0 = 3, chr1 = 9
    write5(16'h8000, 5'h10);
    write5(16'hA000, 5'h03);
    write5(16'hC000, 5'h09);
    probe_chr("chr4k", 5'd3, 5'd9);
    probe_prg("mode0", 4'h4, 4'h5);
    check("mode0_mirroring", {6'h0, mirroring}, 8'd0);

    // Partial sequence aborted by a bit7 write
    do_write(16'h8000, 8'h01);
    do_write(16'h8000, 8'h01);
    do_write(16'h8000, 8'h01);
    do_write(16'h8000, 8'h80);
    probe_prg("abort", 4'h5, 4'hF);
    probe_chr("abort", 5'd3, 5'd9);
    check("abort_mirroring", {6'h0, mirroring}, 8'd0);
    write5(16'h8000, 5'h1E);
    check("after_abort_mirroring", {6'h0, mirroring}, 8'd2);

    // control = 5'h0B: mirroring 3, PRG mode 2, CHR 8 KB
    write5(16'h8000, 5'h0B);
    check("ctl0B_mirroring", {6'h0, mirroring}, 8'd3);
    probe_prg("mode2", 4'h0, 4'h5);
    probe_chr("chr8k", 5'd2, 5'd3);

    // Back-to-back write events: only the first shifts
    @(negedge clkCPU);
    sys_rw = 1'b0; sys_addr = 16'hE000; sys_data = 8'h01;
    @(negedge clkCPU);
    sys_data = 8'h00;
    @(negedge clkCPU);
    sys_rw = 1'b1; sys_addr = 16'h0000;
    @(negedge clkCPU);
    do_write(16'hE000, 8'h01);
    do_write(16'hE000, 8'h01);
    do_write(16'hE000, 8'h00);
    do_write(16'hE000, 8'h01);
    probe_prg("dblwr", 4'h0, 4'h7);
    check("dblwr_ram_en", {7'h0, prg_ram_en}, 8'd0);

    // A write below $8000 between two events clears the double-write flag
    @(negedge clkCPU);
    sys_rw = 1'b0; sys_addr = 16'hE000; sys_data = 8'h00;
    @(negedge clkCPU);
    sys_addr = 16'h6000;
    @(negedge clkCPU);
    sys_addr = 16'hE000;
    @(negedge clkCPU);
    sys_rw = 1'b1; sys_addr = 16'h0000;
    @(negedge clkCPU);
    do_write(16'hE000, 8'h01);
    do_write(16'hE000, 8'h00);
    do_write(16'hE000, 8'h00);
    probe_prg("lowwr", 4'h0, 4'h4);
    check("lowwr_ram_en", {7'h0, prg_ram_en}, 8'd1);

    // enable low: writes ignored, including mid-sequence
    enable = 1'b0;
    write5(16'hE000, 5'h1F);
    probe_prg("dis", 4'h0, 4'h4);
    check("dis_ram_en", {7'h0, prg_ram_en}, 8'd0);
    enable = 1'b1;
    do_write(16'hE000, 8'h01);
    do_write(16'hE000, 8'h01);
    enable = 1'b0;
    write5(16'hE000, 5'h00);
    enable = 1'b1;
    do_write(16'hE000, 8'h00);
    do_write(16'hE000, 8'h00);
    do_write(16'hE000, 8'h01);
    probe_prg("resume", 4'h0, 4'h3);
    check("resume_ram_en", {7'h0, prg_ram_en}, 8'd0);

    // Reset pulse at count = 2
    do_write(16'h8000, 8'h01);
    do_write(16'h8000, 8'h01);
    @(negedge clkCPU);
    reset = 1'b1;
    #2;
    reset = 1'b0;
    #1;
    probe_prg("rst2", 4'h0, 4'hF);
    probe_chr("rst2", 5'd0, 5'd1);
    check("rst2_mirroring", {6'h0, mirroring}, 8'd0);
    check("rst2_ram_en", {7'h0, prg_ram_en}, 8'd1);
    write5(16'h8000, 5'h0E);
    check("rst2_reload_mirroring", {6'h0, mirroring}, 8'd2);
    probe_prg("rst2_reload", 4'h0, 4'hF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
